// File: rtl/skeeball_pkg.sv
// Shared types and constants for the skee-ball front end: FSM states,
// hole bit positions and default game parameters.
package skeeball_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam int NUM_HOLES = 7;
    localparam int HOLE_100  = 6;
    localparam int HOLE_50   = 5;
    localparam int HOLE_40   = 4;
    localparam int HOLE_30   = 3;
    localparam int HOLE_20   = 2;
    localparam int HOLE_10   = 1;
    localparam int HOLE_0    = 0;

    localparam int DEF_BALLS    = 9;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_LOCKOUT  = 8;

    // Keeps only the highest-value hole; later iterations override lower bits.
    function automatic logic [NUM_HOLES-1:0] prio_onehot(input logic [NUM_HOLES-1:0] evt);
        logic [NUM_HOLES-1:0] r;
        r = '0;
        for (int i = HOLE_0; i <= HOLE_100; i++) begin
            if (evt[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/skeeball_debounce.sv
// Single hole sensor conditioner: 2-flop synchronizer, saturating run-length
// counter and rising-edge detect producing a one-cycle event.
module skeeball_debounce
    import skeeball_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sensor,
    output logic o_evt
);

    logic       r_sync1;
    logic       r_sync2;
    logic [3:0] r_cnt;
    logic       r_lvl_d;
    logic       w_lvl;

    assign w_lvl = (r_cnt == 4'(DEBOUNCE_CYCLES));
    assign o_evt = w_lvl & ~r_lvl_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync1 <= i_sensor;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (!w_lvl) begin
                r_cnt <= r_cnt + 4'd1;
            end
            r_lvl_d <= w_lvl;
        end
    end

endmodule

// File: rtl/skeeball_game_ctrl.sv
// Skee-ball game controller: debounces seven hole sensors, emits one-hot hit
// pulses and sequences IDLE/PLAY/OVER/CLEAR. Optional macro SKEEBALL_LOCKOUT_EN.
//
// state | meaning
// IDLE  | no game, playstate low (score cleared)
// PLAY  | counting balls, hits forwarded to accumulator
// OVER  | all balls used, score held visible, hits dropped
// CLEAR | one cycle of playstate low to wipe the score before a new game
module skeeball_game_ctrl
    import skeeball_pkg::*;
#(
    parameter int BALLS           = DEF_BALLS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
`ifdef SKEEBALL_LOCKOUT_EN
    ,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] sensor,
    output logic                 playstate,
    output logic [NUM_HOLES-1:0] hit,
    output logic [3:0]           balls_left,
    output logic                 game_over
);

    state_t               r_state;
    logic                 r_playstate;
    logic [NUM_HOLES-1:0] r_hit;
    logic [3:0]           r_balls;
    logic                 r_game_over;

    logic [NUM_HOLES-1:0] w_evt;
    logic [NUM_HOLES-1:0] w_sel;
    logic                 w_lock_busy;
    logic                 w_accept;

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_db
        skeeball_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_sensor(sensor[g]),
            .o_evt   (w_evt[g])
        );
    end

    assign w_sel    = prio_onehot(w_evt);
    assign w_accept = (r_state == PLAY) && (w_evt != '0) && !w_lock_busy;

`ifdef SKEEBALL_LOCKOUT_EN
    logic [7:0] r_lock;

    assign w_lock_busy = (r_lock != 8'd0);

    // Window covers the LOCKOUT_CYCLES event cycles following an accepted one.
    always_ff @(posedge clk) begin
        if (reset || (r_state != PLAY)) begin
            r_lock <= 8'd0;
        end else if (w_accept) begin
            r_lock <= 8'(LOCKOUT_CYCLES);
        end else if (w_lock_busy) begin
            r_lock <= r_lock - 8'd1;
        end
    end
`else
    assign w_lock_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_playstate <= 1'b0;
            r_hit       <= '0;
            r_balls     <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_hit <= '0;
            case (r_state)
                IDLE: begin
                    r_playstate <= 1'b0;
                    r_game_over <= 1'b0;
                    if (start) begin
                        r_state     <= PLAY;
                        r_playstate <= 1'b1;
                        r_balls     <= 4'(BALLS);
                    end
                end
                PLAY: begin
                    r_playstate <= 1'b1;
                    if (w_accept) begin
                        r_hit <= w_sel;
                        if (r_balls != 4'd0) begin
                            r_balls <= r_balls - 4'd1;
                        end
                        if (r_balls <= 4'd1) begin
                            r_state     <= OVER;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    r_playstate <= 1'b1;
                    r_game_over <= 1'b1;
                    if (start) begin
                        r_state     <= CLEAR;
                        r_playstate <= 1'b0;
                        r_game_over <= 1'b0;
                        r_balls     <= 4'(BALLS);
                    end
                end
                CLEAR: begin
                    r_state     <= PLAY;
                    r_playstate <= 1'b1;
                    r_game_over <= 1'b0;
                    r_balls     <= 4'(BALLS);
                end
                default: begin
                    r_state     <= IDLE;
                    r_playstate <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign playstate  = r_playstate;
    assign hit        = r_hit;
    assign balls_left = r_balls;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// Scoreboard bench for skeeball_game_ctrl: a game-level model predicts each
// hit pulse (value, balls left, cycle) and a monitor checks what the DUT emits.
module tb_skeeball_game_ctrl;

    localparam int BALLS   = 9;
    localparam int DEB     = 4;
    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_OVER  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] sensor;
    logic       playstate;
    logic [6:0] hit;
    logic [3:0] balls_left;
    logic       game_over;

    always #5 clk = ~clk;

    skeeball_game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sensor    (sensor),
        .playstate (playstate),
        .hit       (hit),
        .balls_left(balls_left),
        .game_over (game_over)
    );

    typedef struct {
        logic [6:0] hit;
        logic [3:0] balls;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   mdl_phase = M_IDLE;
    int   mdl_balls = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [6:0] top_hole(input logic [6:0] m);
        for (int i = 6; i >= 0; i--) begin
            if (m[i]) return 7'(1 << i);
        end
        return 7'd0;
    endfunction

    always @(negedge clk) begin
        if (mon_en && hit !== 7'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_hit", 32'(hit), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hit_value", 32'(hit), 32'(mon_e.hit));
                check("hit_balls", 32'(balls_left), 32'(mon_e.balls));
                check("hit_playstate", 32'(playstate), 32'd1);
                check("hit_time", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    // Model: a sensor held for at least DEB samples makes one event, seen as a
    // hit DEB+3 cycles after the drive point; scored only while a game is live.
    task automatic expect_hit(input logic [6:0] mask, input int due);
        exp_t e;
        if (mdl_phase == M_PLAY) begin
            mdl_balls--;
            e.hit   = top_hole(mask);
            e.balls = 4'(mdl_balls);
            e.due   = due;
            sb.push_back(e);
            if (mdl_balls == 0) mdl_phase = M_OVER;
        end
    endtask

    task automatic issue(input logic [6:0] mask, input int dur);
        @(negedge clk);
        if (dur >= DEB) expect_hit(mask, cyc + 3 + DEB);
        sensor = mask;
        repeat (dur) @(negedge clk);
        sensor = 7'd0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic press_start();
        int ph;
        ph = mdl_phase;
        if (ph == M_OVER) begin
            check("over_game_over", 32'(game_over), 32'd1);
            check("over_playstate", 32'(playstate), 32'd1);
            check("over_balls", 32'(balls_left), 32'd0);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (ph == M_IDLE) begin
            check("start_playstate", 32'(playstate), 32'd1);
            check("start_balls", 32'(balls_left), 32'(BALLS));
            check("start_game_over", 32'(game_over), 32'd0);
            mdl_phase = M_PLAY;
            mdl_balls = BALLS;
        end else if (ph == M_OVER) begin
            check("clear_playstate", 32'(playstate), 32'd0);
            check("clear_game_over", 32'(game_over), 32'd0);
            @(negedge clk);
            check("restart_playstate", 32'(playstate), 32'd1);
            check("restart_balls", 32'(balls_left), 32'(BALLS));
            mdl_phase = M_PLAY;
            mdl_balls = BALLS;
        end else begin
            check("play_start_ignored_ps", 32'(playstate), 32'd1);
            check("play_start_ignored_balls", 32'(balls_left), 32'(mdl_balls));
        end
    endtask

    task automatic play_out();
        while (mdl_phase == M_PLAY) issue(7'(1 << $urandom_range(0, 6)), 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] mask;
        int         c0;
        reset  = 1'b1;
        start  = 1'b0;
        sensor = 7'd0;
        repeat (3) @(negedge clk);
        check("reset_playstate", 32'(playstate), 32'd0);
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_balls", 32'(balls_left), 32'd0);
        check("reset_game_over", 32'(game_over), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        press_start();
        issue(7'b0100000, 10);
        issue(7'b1000100, 6);
        issue(7'b0001000, 3);
        check("glitch_balls", 32'(balls_left), 32'(mdl_balls));
        issue(7'b0000001, DEB);
        issue(7'b0000010, DEB - 1);
        check("short_balls", 32'(balls_left), 32'(mdl_balls));
        play_out();
        issue(7'b0010000, 6);
        check("over_hold_playstate", 32'(playstate), 32'd1);
        press_start();

        for (int t = 0; t < 40; t++) begin
            if (mdl_phase == M_OVER) begin
                if ($urandom_range(0, 1) == 1) press_start();
            end else if ($urandom_range(0, 5) == 0) begin
                press_start();
            end
            mask = 7'(1 << $urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) mask = mask | 7'(1 << $urandom_range(0, 6));
            issue(mask, $urandom_range(1, 8));
        end

`ifdef SKEEBALL_LOCKOUT_EN
        if (mdl_phase != M_PLAY) press_start();
        @(negedge clk);
        c0 = cyc;
        expect_hit(7'b0010000, c0 + 3 + DEB);
        sensor = 7'b0010000;
        repeat (3) @(negedge clk);
        sensor = 7'b0010010;
        repeat (10) @(negedge clk);
        sensor = 7'd0;
        repeat (DEB + 8) @(negedge clk);
        check("lockout_balls", 32'(balls_left), 32'(mdl_balls));
`endif

        if (mdl_phase != M_PLAY || mdl_balls < 5) begin
            play_out();
            press_start();
        end
        while (mdl_balls > 5) issue(7'(1 << $urandom_range(0, 6)), 5);
        check("pre_reset_balls", 32'(balls_left), 32'd5);
        @(negedge clk);
        sensor = 7'b0000100;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_playstate", 32'(playstate), 32'd0);
        check("midreset_hit", 32'(hit), 32'd0);
        check("midreset_balls", 32'(balls_left), 32'd0);
        check("midreset_game_over", 32'(game_over), 32'd0);
        reset = 1'b0;
        mdl_phase = M_IDLE;
        mdl_balls = 0;
        repeat (5) @(negedge clk);
        sensor = 7'd0;
        repeat (15) @(negedge clk);
        check("idle_after_reset_playstate", 32'(playstate), 32'd0);
        check("idle_after_reset_balls", 32'(balls_left), 32'd0);

        c0 = 0;
        while (sb.size() != 0 && c0 < 30) begin
            @(negedge clk);
            c0++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
